// File: rtl/uart_msg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_msg_pkg
// Description : Shared byte codes, FSM state encoding and request priority
//               indices for the UART game-event message scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_msg_pkg;

    // Byte sent on the UART for each event type
    localparam logic [7:0] MSG_GAME_OVER = 8'h4C;
    localparam logic [7:0] MSG_HIT       = 8'h48;
    localparam logic [7:0] MSG_READY     = 8'h52;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_e;

    // Request index; lower value = higher priority
    typedef logic [1:0] prio_idx_t;
    localparam prio_idx_t PRIO_GO  = 2'd0;
    localparam prio_idx_t PRIO_HIT = 2'd1;
    localparam prio_idx_t PRIO_RDY = 2'd2;

    // Map a request index to the byte that announces it
    function automatic logic [7:0] prio_byte(input prio_idx_t idx);
        case (idx)
            PRIO_GO:  prio_byte = MSG_GAME_OVER;
            PRIO_HIT: prio_byte = MSG_HIT;
            default:  prio_byte = MSG_READY;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/msg_pending_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : msg_pending_arbiter
// Description : Holds pending game-event requests (game-over flag, saturating
//               hit counter, ready flag) and selects the highest-priority one.
// Revision    : 1.0 - initial release
// ============================================================================
module msg_pending_arbiter
    import uart_msg_pkg::*;
#(
    parameter int HIT_CNT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable_i,
    input  logic            ev_go_i,
    input  logic            ev_rdy_i,
    input  logic            ev_hit_i,
    input  logic            consume_i,
    input  logic            requeue_i,
    input  prio_idx_t       requeue_idx_i,
    output logic            any_pend_o,
    output prio_idx_t       sel_idx_o,
    output logic [7:0]      sel_byte_o,
    output logic [2:0]      pending_o,
    output logic            hit_overflow_o
);

    localparam int                   SUM_W   = HIT_CNT_W + 2;
    localparam logic [HIT_CNT_W-1:0] HIT_MAX = '1;

    logic                 go_q, go_d;
    logic                 rdy_q, rdy_d;
    logic                 ovf_q, ovf_d;
    logic [HIT_CNT_W-1:0] hit_q, hit_d;

    logic                 w_go_set, w_go_clr;
    logic                 w_rdy_set, w_rdy_clr;
    logic                 w_hit_rq, w_hit_dec;
    logic [SUM_W-1:0]     w_hit_sum;

    // Fixed-priority select: game over, then hit, then ready
    always_comb begin
        sel_idx_o = PRIO_RDY;
        if (go_q) begin
            sel_idx_o = PRIO_GO;
        end else if (hit_q != '0) begin
            sel_idx_o = PRIO_HIT;
        end
        sel_byte_o     = prio_byte(sel_idx_o);
        any_pend_o     = go_q || (hit_q != '0) || rdy_q;
        pending_o      = {go_q, (hit_q != '0), rdy_q};
        hit_overflow_o = ovf_q;
    end

    // Next pending state: a set beats a same-cycle clear, disable wipes all
    always_comb begin
        w_go_set  = ev_go_i  || (requeue_i && (requeue_idx_i == PRIO_GO));
        w_rdy_set = ev_rdy_i || (requeue_i && (requeue_idx_i == PRIO_RDY));
        w_hit_rq  = requeue_i && (requeue_idx_i == PRIO_HIT);
        w_go_clr  = consume_i && (sel_idx_o == PRIO_GO);
        w_rdy_clr = consume_i && (sel_idx_o == PRIO_RDY);
        w_hit_dec = consume_i && (sel_idx_o == PRIO_HIT);

        // Decrement only happens with a non-zero count, so no underflow
        w_hit_sum = SUM_W'(hit_q) + SUM_W'(ev_hit_i) + SUM_W'(w_hit_rq)
                  - SUM_W'(w_hit_dec);

        go_d  = enable_i && (w_go_set  || (go_q  && !w_go_clr));
        rdy_d = enable_i && (w_rdy_set || (rdy_q && !w_rdy_clr));

        if (!enable_i) begin
            hit_d = '0;
        end else if (w_hit_sum > SUM_W'(HIT_MAX)) begin
            hit_d = HIT_MAX;
        end else begin
            hit_d = w_hit_sum[HIT_CNT_W-1:0];
        end

        // Sticky: an event hit arrived while the counter was already full
        ovf_d = ovf_q || (enable_i && ev_hit_i && (hit_q == HIT_MAX));
    end

    // Pending request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            go_q  <= 1'b0;
            rdy_q <= 1'b0;
            ovf_q <= 1'b0;
            hit_q <= '0;
        end else begin
            go_q  <= go_d;
            rdy_q <= rdy_d;
            ovf_q <= ovf_d;
            hit_q <= hit_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_msg_scheduler
// Description : Serialises game events onto a shared UART TX, one byte per
//               event, with inter-frame gap, TX timeout and game-over repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_msg_scheduler
    import uart_msg_pkg::*;
#(
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int GO_REPEAT      = 3,
    parameter int HIT_CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ev_game_over,
    input  logic       ev_ready,
    input  logic       ev_hit,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic [2:0] pending,
    output logic       hit_overflow,
    output logic       timeout_err
);

    localparam int               CNT_MAX   = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int               CNT_W     = $clog2(CNT_MAX + 1);
    localparam int               REP_W     = $clog2(GO_REPEAT + 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LOAD  = REP_W'(GO_REPEAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [7:0]       data_q, data_d;
    prio_idx_t        cur_q, cur_d;
    logic             tx_start_q;
    logic             tout_q, tout_d;

    logic             w_take, w_timeout, w_gap_done;
    logic             w_any_pend, w_ovf;
    prio_idx_t        w_sel_idx;
    logic [7:0]       w_sel_byte;
    logic [2:0]       w_pending;

    assign w_take     = (state_q == IDLE) && enable && w_any_pend;
    assign w_timeout  = (state_q == WAIT) && !tx_done && (cnt_q == TOUT_LAST);
    assign w_gap_done = (state_q == GAP) && (cnt_q == GAP_LAST);

    msg_pending_arbiter #(
        .HIT_CNT_W (HIT_CNT_W)
    ) u_arb (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable),
        .ev_go_i        (ev_game_over),
        .ev_rdy_i       (ev_ready),
        .ev_hit_i       (ev_hit),
        .consume_i      (w_take),
        .requeue_i      (w_timeout),
        .requeue_idx_i  (cur_q),
        .any_pend_o     (w_any_pend),
        .sel_idx_o      (w_sel_idx),
        .sel_byte_o     (w_sel_byte),
        .pending_o      (w_pending),
        .hit_overflow_o (w_ovf)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: select, one-cycle start, wait for done/timeout, gap
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_take) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (tx_done || w_timeout) state_d = GAP;
            GAP:     if (w_gap_done) state_d = (rep_q != '0) ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; tx_start comes straight from a register
    always_comb begin
        busy         = (state_q != IDLE);
        tx_start     = tx_start_q;
        tx_data      = data_q;
        pending      = w_pending;
        hit_overflow = w_ovf;
        timeout_err  = tout_q;
    end

    // Datapath next values: cycle counter, repeat count, latched byte
    always_comb begin
        cnt_d  = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
        data_d = w_take ? w_sel_byte : data_q;
        cur_d  = w_take ? w_sel_idx  : cur_q;

        rep_d = rep_q;
        if (w_take) begin
            rep_d = (w_sel_idx == PRIO_GO) ? REP_LOAD : '0;
        end else if (w_gap_done && (rep_q != '0)) begin
            rep_d = rep_q - REP_W'(1);
        end
        // A timed-out game over is re-queued and restarts its full sequence
        if (w_timeout || !enable) begin
            rep_d = '0;
        end

        tout_d = tout_q || w_timeout;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            rep_q      <= '0;
            data_q     <= 8'h00;
            cur_q      <= PRIO_GO;
            tx_start_q <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rep_q      <= rep_d;
            data_q     <= data_d;
            cur_q      <= cur_d;
            tx_start_q <= (state_d == START);
            tout_q     <= tout_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_msg_scheduler
// Description : Self-checking bench: event stimulus feeds a request-level
//               model that queues expected bytes; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_msg_scheduler;

    localparam int GAP  = 20;
    localparam int TOUT = 300;
    localparam int REP  = 3;
    localparam int HCW  = 4;
    localparam int HMAX = (1 << HCW) - 1;
    localparam logic [7:0] B_GO  = 8'h4C;
    localparam logic [7:0] B_HIT = 8'h48;
    localparam logic [7:0] B_RDY = 8'h52;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       ev_go = 1'b0, ev_rdy = 1'b0, ev_hit = 1'b0;
    logic       resp_done = 1'b0, main_done = 1'b0;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic [2:0] pending;
    logic       hit_overflow, timeout_err;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    int         resp_delay = 40;
    int         drop_at = -1;
    int         resp_frames = 0;
    bit         resp_abort = 1'b0;
    int         cyc = 0;
    int         last_start = -1;
    logic [7:0] cur_byte = 8'h00;

    // Request-level model of what is waiting to be announced
    bit m_go, m_rdy, m_ovf, m_tout;
    int m_hit;

    assign tx_done = resp_done | main_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_msg_scheduler #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TOUT),
        .GO_REPEAT      (REP),
        .HIT_CNT_W      (HCW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .ev_game_over (ev_go),
        .ev_ready     (ev_rdy),
        .ev_hit       (ev_hit),
        .tx_done      (tx_done),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .busy         (busy),
        .pending      (pending),
        .hit_overflow (hit_overflow),
        .timeout_err  (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every tx_start must match the head of the expected queue
    always @(negedge clk) begin
        if (rst) begin
            last_start = -1;
        end else if (tx_start === 1'b1) begin
            if (last_start >= 0)
                check("start_spacing", ((cyc - last_start) >= GAP + 2), 1);
            last_start = cyc;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tx_start: got byte %h expected no frame", tx_data);
            end else begin
                cur_byte = sb.pop_front();
                check("tx_byte", tx_data, cur_byte);
            end
        end
    end

    // UART TX stand-in: answers tx_done after resp_delay cycles unless dropped
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx_start === 1'b1) begin
                resp_frames++;
                if (resp_frames != drop_at) begin
                    resp_abort = 1'b0;
                    for (int i = 0; i < resp_delay - 1; i++) begin
                        @(negedge clk);
                        if (rst) begin
                            resp_abort = 1'b1;
                            break;
                        end
                    end
                    if (!resp_abort) begin
                        check("tx_data_hold", tx_data, cur_byte);
                        resp_done = 1'b1;
                        @(negedge clk);
                        resp_done = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic model_event(input logic [2:0] v);  // {go, hit, ready}
        if (enable) begin
            if (v[2]) m_go = 1'b1;
            if (v[0]) m_rdy = 1'b1;
            if (v[1]) begin
                if (m_hit == HMAX) m_ovf = 1'b1;
                else m_hit++;
            end
        end
    endtask

    task automatic model_take();
        if (m_go) begin
            m_go = 1'b0;
            repeat (REP) sb.push_back(B_GO);
        end else if (m_hit > 0) begin
            m_hit--;
            sb.push_back(B_HIT);
        end else if (m_rdy) begin
            m_rdy = 1'b0;
            sb.push_back(B_RDY);
        end
    endtask

    task automatic model_drain();
        while (m_go || m_hit > 0 || m_rdy) model_take();
    endtask

    task automatic fire(input logic [2:0] v);
        ev_go = v[2]; ev_hit = v[1]; ev_rdy = v[0];
        @(negedge clk);
        ev_go = 1'b0; ev_hit = 1'b0; ev_rdy = 1'b0;
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (tx_start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (tx_start !== 1'b1) check("wait_tx_start_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0 && pending === 3'b000 && tx_start === 1'b0) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) check("wait_idle_timeout", 0, 1);
    endtask

    task automatic end_of_round(input string tag);
        check({tag, "_queue_empty"}, sb.size(), 0);
        check({tag, "_pending"}, pending, 0);
        check({tag, "_hit_overflow"}, hit_overflow, m_ovf);
        check({tag, "_timeout_err"}, timeout_err, m_tout);
    endtask

    // First batch in one cycle, extra events while the first frame is in flight
    task automatic run_round(input logic [2:0] first, input int n_extra, input bit hits_only);
        logic [2:0] v;
        model_event(first);
        model_take();
        fire(first);
        wait_start(50);
        for (int i = 0; i < n_extra; i++) begin
            v = hits_only ? 3'b010 : 3'($urandom_range(0, 7));
            model_event(v);
            fire(v);
        end
        model_drain();
        wait_idle(4000);
        end_of_round("round");
    endtask

    initial begin
        m_go = 0; m_rdy = 0; m_ovf = 0; m_tout = 0; m_hit = 0;
        enable = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_outputs", {tx_start, tx_data, busy, pending, hit_overflow, timeout_err}, 0);
        rst = 1'b0;

        // Single ready: tx_start exactly in the cycle after edge N+1
        model_event(3'b001);
        model_take();
        ev_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ev_rdy = 1'b0;
        check("latency_early_start", tx_start, 0);
        @(posedge clk);
        #1;
        check("latency_start", tx_start, 1);
        check("latency_data", tx_data, B_RDY);
        check("latency_busy", busy, 1);
        wait_idle(500);
        end_of_round("single_ready");

        // Simultaneous events: 4C x3, 48, 52
        run_round(3'b111, 0, 1'b0);

        // 20 hits during one long frame: saturate at 15, overflow set
        run_round(3'b001, 20, 1'b1);

        // Withheld tx_done: ready is re-sent after the timeout
        m_tout = 1'b1;
        sb.push_back(B_RDY);
        sb.push_back(B_RDY);
        drop_at = resp_frames + 1;
        fire(3'b001);
        wait_idle(2000);
        end_of_round("timeout_ready");

        // tx_done while idle is ignored
        main_done = 1'b1;
        @(negedge clk);
        main_done = 1'b0;
        repeat (10) @(negedge clk);
        check("done_in_idle_busy", busy, 0);
        check("done_in_idle_pending", pending, 0);

        // Timeout on the second game-over repeat restarts the full sequence
        repeat (REP + 2) sb.push_back(B_GO);
        drop_at = resp_frames + 2;
        fire(3'b100);
        wait_idle(3000);
        end_of_round("timeout_go");

        // Randomised rounds
        for (int r = 0; r < 8; r++)
            run_round(3'($urandom_range(1, 7)), $urandom_range(0, 20), 1'b0);

        // Disable during WAIT with two hits pending
        model_event(3'b001);
        model_take();
        fire(3'b001);
        wait_start(50);
        fire(3'b010);
        fire(3'b010);
        check("dis_two_hits_pending", pending, 3'b010);
        enable = 1'b0;
        m_go = 0; m_rdy = 0; m_hit = 0;
        @(negedge clk);
        check("dis_pending_cleared", pending, 0);
        model_event(3'b010);
        fire(3'b010);
        check("dis_hit_ignored", pending, 0);
        wait_idle(500);
        end_of_round("disable");
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("reenable_pending", pending, 0);
        check("reenable_busy", busy, 0);

        // Reset mid-frame aborts immediately and clears sticky errors
        model_event(3'b100);
        model_take();
        fire(3'b100);
        wait_start(50);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_frame", {tx_start, tx_data, busy, pending, hit_overflow, timeout_err}, 0);
        sb.delete();
        m_go = 0; m_rdy = 0; m_hit = 0; m_ovf = 0; m_tout = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("after_rst_quiet", {busy, pending}, 0);
        run_round(3'b100, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_msg_scheduler.md
Name: uart_msg_scheduler

Overview:
Sequences multiplayer game events (game over, player ready, player hit) onto a single shared UART transmitter, one byte per event. Events are latched as pending requests, so simultaneous or back-to-back events are never lost. A fixed-priority arbiter selects the next request and drives the TX start/done handshake. The block enforces an inter-frame gap and repeats the game-over byte for robustness. It sits between the game-logic event sources and the UART TX core.

Parameters:
GAP_CYCLES, 1000, idle clk cycles inserted after each completed or abandoned frame
TIMEOUT_CYCLES, 100000, max cycles waiting for tx_done before abandoning the frame
GO_REPEAT, 3, number of times the game-over byte is sent per game-over event (>=1)
HIT_CNT_W, 4, width of the saturating pending-hit counter

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
enable  in  1  multiplayer mode; low = discard all pending requests and ignore new events
ev_game_over  in  1  single-cycle event pulse
ev_ready  in  1  single-cycle event pulse
ev_hit  in  1  single-cycle event pulse
tx_done  in  1  single-cycle pulse from UART TX at end of stop bit
tx_start  out  1  single-cycle request to UART TX (registered)
tx_data  out  8  byte to send; stable from the tx_start cycle until tx_done
busy  out  1  high in any state other than IDLE
pending  out  3  {game_over_pend, hit_cnt!=0, ready_pend}
hit_overflow  out  1  sticky; a hit event arrived while the counter was saturated
timeout_err  out  1  sticky; a frame was abandoned on timeout

Behaviour:
- Reset values: all outputs 0, tx_data 8'h00, state IDLE, all pending flags, counters and repeat count cleared. Reset mid-frame aborts immediately; tx_start does not assert again until a new pending request exists.
- Byte codes: game over 8'h4C, hit 8'h48, ready 8'h52.
- Pending capture (enable high):
  - ev_game_over sets go_pend.
  - ev_ready sets rdy_pend.
  - ev_hit increments hit_cnt; it saturates at 2^HIT_CNT_W-1 and sets hit_overflow on an increment attempt while saturated.
  - If a set/increment and a clear/decrement hit the same cycle, the set wins and the counter is unchanged.
- Priority: game over > hit > ready. A request is consumed (flag cleared or counter decremented) when it is selected in IDLE.
- FSM:
  - IDLE: if enable and any request is pending, latch the selected byte into tx_data; for game over, load rep_cnt = GO_REPEAT-1. Go to START.
  - START: tx_start=1 for exactly this one cycle. Go to WAIT.
  - WAIT: count cycles.
    - On tx_done, go to GAP.
    - If the count reaches TIMEOUT_CYCLES with no tx_done, set timeout_err, re-queue the request (set its flag or increment its counter), and go to GAP. A game-over re-queue restarts the full GO_REPEAT sequence.
    - A tx_done seen in any state other than WAIT is ignored.
  - GAP: count GAP_CYCLES cycles.
    - If rep_cnt>0, decrement rep_cnt and go to START; tx_data is unchanged.
    - Otherwise go to IDLE.
- Latency: an event pulse sampled at edge N with FSM in IDLE gives tx_start high in the cycle after edge N+1. Minimum spacing between consecutive tx_start pulses = frame time + GAP_CYCLES + 2.
- enable low: pending flags, hit_cnt and rep_cnt are cleared every cycle and events are ignored. A frame already in START or WAIT completes normally (the UART cannot abort), then passes through GAP to IDLE. Sticky errors are held.
- Counters are sized to $clog2 of their limit (+1). The gap and timeout counters reset on every state entry.

Decomposition:
- Shared package uart_msg_pkg: byte constants MSG_GAME_OVER/MSG_HIT/MSG_READY, FSM state enum (IDLE, START, WAIT, GAP), priority index constants.
- One natural sub-module: msg_pending_arbiter. It holds the pending flags, the hit counter and the fixed-priority select/consume logic. The FSM and counters remain in the top module.

Test Plan:
- Single ev_ready, with tx_done returned 100 cycles after tx_start -> one tx_start, tx_data=8'h52 two cycles after the pulse; busy for 100+GAP_CYCLES+~2 cycles; pending=0 afterwards.
- ev_hit, ev_ready and ev_game_over in the same cycle -> byte order 4C,4C,4C (GO_REPEAT=3), then 48, then 52; each consecutive tx_start pair separated by at least GAP_CYCLES.
- 20 ev_hit pulses during one long frame (HIT_CNT_W=4) -> hit_cnt saturates at 15 and hit_overflow=1; exactly 15 frames of 8'h48 follow.
- tx_done withheld -> after TIMEOUT_CYCLES, timeout_err=1 and the same byte is re-sent after GAP; a tx_done pulse while in IDLE has no effect.
- enable dropped while in WAIT with 2 hits pending -> the current frame finishes, pending=0, no further tx_start; an ev_hit while enable is low produces nothing.
- rst asserted in WAIT -> next cycle tx_start=0, busy=0, tx_data=00, errors cleared; a subsequent ev_game_over sends 4C three times.
